// File: rtl/fpu_pkg.sv
// Shared floating-point types and format constants.
package fpu_pkg;

  // Operand classification after denormal flushing.
  typedef enum logic [1:0] {
    ClsZero,
    ClsNorm,
    ClsInf,
    ClsNan
  } op_class_e;

  // Result category decided in S1 and carried down the pipe.
  typedef enum logic [2:0] {
    KindNum,
    KindZero,
    KindInf,
    KindNan,
    KindInv
  } res_kind_e;

  function automatic int unsigned exp_bias(input int unsigned ew);
    return (32'd1 << (ew - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_all_ones(input int unsigned ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalise, round and pack the raw significand product into the output format.
module fp_mul_round
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 7,
  parameter bit          ROUND_EN   = 1'b1
) (
  input  res_kind_e                   kind_i,
  input  logic                        sign_i,
  input  logic [EXP_WIDTH+1:0]        exp_i,
  input  logic [2*FRAC_WIDTH+1:0]     prod_i,
  output logic                        sign_o,
  output logic [EXP_WIDTH-1:0]        exp_o,
  output logic [FRAC_WIDTH-1:0]       frac_o,
  output logic                        ovf_o,
  output logic                        unf_o,
  output logic                        inv_o
);

  localparam int unsigned ProdW = 2 * FRAC_WIDTH + 2;
  localparam int unsigned ExpSW = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0]  ExpOnes  = EXP_WIDTH'(exp_all_ones(EXP_WIDTH));
  localparam logic [ExpSW-1:0]      ExpOnesW = {2'b00, ExpOnes};
  localparam logic [FRAC_WIDTH-1:0] NanFrac  = {1'b1, {(FRAC_WIDTH - 1) {1'b0}}};

  logic                  msb, guard, sticky, inc, ovf, unf;
  logic [FRAC_WIDTH-1:0] frac_t;
  logic [FRAC_WIDTH:0]   frac_r;
  logic [ExpSW-1:0]      exp_f;

  // Exponents are two's complement in ExpSW bits; the MSB marks a negative value.
  always_comb begin
    msb = prod_i[ProdW-1];
    if (msb) begin
      frac_t = prod_i[ProdW-2 -: FRAC_WIDTH];
      guard  = prod_i[FRAC_WIDTH];
      sticky = |prod_i[FRAC_WIDTH-1:0];
    end else begin
      frac_t = prod_i[ProdW-3 -: FRAC_WIDTH];
      guard  = prod_i[FRAC_WIDTH-1];
      sticky = |prod_i[FRAC_WIDTH-2:0];
    end
    inc    = ROUND_EN && guard && (sticky || frac_t[0]);
    frac_r = {1'b0, frac_t} + {{FRAC_WIDTH{1'b0}}, inc};
    // A rounding carry leaves the fraction bits at zero and bumps the exponent.
    exp_f  = exp_i + {{(ExpSW - 1) {1'b0}}, msb} + {{(ExpSW - 1) {1'b0}}, frac_r[FRAC_WIDTH]};
    ovf    = !exp_f[ExpSW-1] && (exp_f >= ExpOnesW);
    unf    = exp_f[ExpSW-1] || (exp_f == '0);

    sign_o = sign_i;
    exp_o  = exp_f[EXP_WIDTH-1:0];
    frac_o = frac_r[FRAC_WIDTH-1:0];
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    inv_o  = 1'b0;
    case (kind_i)
      KindNan: begin
        sign_o = 1'b0;
        exp_o  = ExpOnes;
        frac_o = NanFrac;
      end
      KindInv: begin
        sign_o = 1'b0;
        exp_o  = ExpOnes;
        frac_o = NanFrac;
        inv_o  = 1'b1;
      end
      KindInf: begin
        exp_o  = ExpOnes;
        frac_o = '0;
      end
      KindZero: begin
        exp_o  = '0;
        frac_o = '0;
      end
      default: begin
        if (ovf) begin
          exp_o  = ExpOnes;
          frac_o = '0;
          ovf_o  = 1'b1;
        end else if (unf) begin
          exp_o  = '0;
          frac_o = '0;
          unf_o  = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
module fp_mul_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 7,
  parameter bit          ROUND_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op1_sign,
  input  logic [EXP_WIDTH-1:0]  op1_exp,
  input  logic [FRAC_WIDTH-1:0] op1_frac,
  input  logic                  op2_sign,
  input  logic [EXP_WIDTH-1:0]  op2_exp,
  input  logic [FRAC_WIDTH-1:0] op2_frac,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  res_sign,
  output logic [EXP_WIDTH-1:0]  res_exp,
  output logic [FRAC_WIDTH-1:0] res_frac,
  output logic                  flag_ovf,
  output logic                  flag_unf,
  output logic                  flag_inv
);

  localparam int unsigned SigW  = FRAC_WIDTH + 1;
  localparam int unsigned ProdW = 2 * SigW;
  localparam int unsigned ExpSW = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0] ExpOnes = EXP_WIDTH'(exp_all_ones(EXP_WIDTH));
  localparam logic [ExpSW-1:0]     Bias    = ExpSW'(exp_bias(EXP_WIDTH));

  function automatic op_class_e classify(input logic [EXP_WIDTH-1:0] e,
                                         input logic [FRAC_WIDTH-1:0] f);
    if (e == '0) return ClsZero;
    if (e != ExpOnes) return ClsNorm;
    if (f == '0) return ClsInf;
    return ClsNan;
  endfunction

  logic s1_en, s2_en, s3_en;
  logic s1_valid_q, s2_valid_q, s3_valid_q;

  res_kind_e        s1_kind_d, s1_kind_q, s2_kind_q;
  op_class_e        cls1, cls2;
  logic [ExpSW-1:0] exp_sum, s1_exp_q, s2_exp_q;
  logic             s1_sign_q, s2_sign_q;
  logic [SigW-1:0]  s1_sig1_q, s1_sig2_q;
  logic [ProdW-1:0] s2_prod_q;

  logic                  rnd_sign, rnd_ovf, rnd_unf, rnd_inv;
  logic [EXP_WIDTH-1:0]  rnd_exp;
  logic [FRAC_WIDTH-1:0] rnd_frac;

  logic                  res_sign_q, flag_ovf_q, flag_unf_q, flag_inv_q;
  logic [EXP_WIDTH-1:0]  res_exp_q;
  logic [FRAC_WIDTH-1:0] res_frac_q;

  // A stage may load when empty or when its current contents move on this cycle.
  assign s3_en    = !s3_valid_q || out_ready;
  assign s2_en    = !s2_valid_q || s3_en;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // S1: classify operands, decide special-case result kind, sum exponents.
  always_comb begin
    cls1      = classify(op1_exp, op1_frac);
    cls2      = classify(op2_exp, op2_frac);
    exp_sum   = {2'b00, op1_exp} + {2'b00, op2_exp} - Bias;
    s1_kind_d = KindNum;
    if (cls1 == ClsNan || cls2 == ClsNan) begin
      s1_kind_d = KindNan;
    end else if ((cls1 == ClsInf && cls2 == ClsZero) || (cls1 == ClsZero && cls2 == ClsInf)) begin
      s1_kind_d = KindInv;
    end else if (cls1 == ClsInf || cls2 == ClsInf) begin
      s1_kind_d = KindInf;
    end else if (cls1 == ClsZero || cls2 == ClsZero) begin
      s1_kind_d = KindZero;
    end
  end

  // S1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= KindZero;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_sig1_q  <= '0;
      s1_sig2_q  <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_kind_q <= s1_kind_d;
        s1_sign_q <= op1_sign ^ op2_sign;
        s1_exp_q  <= exp_sum;
        s1_sig1_q <= {1'b1, op1_frac};
        s1_sig2_q <= {1'b1, op2_frac};
      end
    end
  end

  // S2 register: significand multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_kind_q  <= KindZero;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_prod_q  <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_kind_q <= s1_kind_q;
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= s1_exp_q;
        s2_prod_q <= ProdW'(s1_sig1_q) * ProdW'(s1_sig2_q);
      end
    end
  end

  fp_mul_round #(
    .EXP_WIDTH (EXP_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .ROUND_EN  (ROUND_EN)
  ) u_round (
    .kind_i(s2_kind_q),
    .sign_i(s2_sign_q),
    .exp_i (s2_exp_q),
    .prod_i(s2_prod_q),
    .sign_o(rnd_sign),
    .exp_o (rnd_exp),
    .frac_o(rnd_frac),
    .ovf_o (rnd_ovf),
    .unf_o (rnd_unf),
    .inv_o (rnd_inv)
  );

  // S3 register: packed result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_frac_q <= '0;
      flag_ovf_q <= 1'b0;
      flag_unf_q <= 1'b0;
      flag_inv_q <= 1'b0;
    end else if (s3_en) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        res_sign_q <= rnd_sign;
        res_exp_q  <= rnd_exp;
        res_frac_q <= rnd_frac;
        flag_ovf_q <= rnd_ovf;
        flag_unf_q <= rnd_unf;
        flag_inv_q <= rnd_inv;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign res_sign  = res_sign_q;
  assign res_exp   = res_exp_q;
  assign res_frac  = res_frac_q;
  assign flag_ovf  = flag_ovf_q;
  assign flag_unf  = flag_unf_q;
  assign flag_inv  = flag_inv_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench: directed vectors, randomised traffic against a value-level model,
// back-pressure and reset sequences. Two DUTs share inputs: round-to-nearest-even and truncate.
module tb_fp_mul_pipe;

  localparam int EW = 8;
  localparam int FW = 7;
  localparam int Bias = 127;
  localparam int ExpMax = 255;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
    logic          ovf;
    logic          unf;
    logic          inv;
  } res_t;

  typedef struct packed {
    logic          s1;
    logic [EW-1:0] e1;
    logic [FW-1:0] f1;
    logic          s2;
    logic [EW-1:0] e2;
    logic [FW-1:0] f2;
    res_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_ready_t, out_valid, out_valid_t, out_ready;
  logic          op1_sign, op2_sign;
  logic [EW-1:0] op1_exp, op2_exp;
  logic [FW-1:0] op1_frac, op2_frac;
  logic          res_sign, flag_ovf, flag_unf, flag_inv;
  logic [EW-1:0] res_exp;
  logic [FW-1:0] res_frac;
  logic          res_sign_t, flag_ovf_t, flag_unf_t, flag_inv_t;
  logic [EW-1:0] res_exp_t;
  logic [FW-1:0] res_frac_t;
  res_t          got, got_t;

  assign got   = {res_sign, res_exp, res_frac, flag_ovf, flag_unf, flag_inv};
  assign got_t = {res_sign_t, res_exp_t, res_frac_t, flag_ovf_t, flag_unf_t, flag_inv_t};

  fp_mul_pipe #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .ROUND_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1_sign(op1_sign), .op1_exp(op1_exp), .op1_frac(op1_frac),
    .op2_sign(op2_sign), .op2_exp(op2_exp), .op2_frac(op2_frac),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sign(res_sign), .res_exp(res_exp), .res_frac(res_frac),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
  );

  fp_mul_pipe #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .ROUND_EN(1'b0)) u_dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .op1_sign(op1_sign), .op1_exp(op1_exp), .op1_frac(op1_frac),
    .op2_sign(op2_sign), .op2_exp(op2_exp), .op2_frac(op2_frac),
    .out_valid(out_valid_t), .out_ready(out_ready),
    .res_sign(res_sign_t), .res_exp(res_exp_t), .res_frac(res_frac_t),
    .flag_ovf(flag_ovf_t), .flag_unf(flag_unf_t), .flag_inv(flag_inv_t)
  );

  int checks = 0;
  int errors = 0;
  res_t exp_rne_q[$];
  res_t exp_trn_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value-level reference: exact integer product, then round the magnitude by remainder.
  function automatic res_t model(input logic s1, input logic [EW-1:0] e1, input logic [FW-1:0] f1,
                                 input logic s2, input logic [EW-1:0] e2, input logic [FW-1:0] f2,
                                 input bit rnd);
    res_t r;
    bit nan1, nan2, inf1, inf2, zero1, zero2;
    int p, k, sh, q, rem, half, be;
    r     = '0;
    r.s   = s1 ^ s2;
    zero1 = (e1 == 0);
    zero2 = (e2 == 0);
    inf1  = (e1 == ExpMax) && (f1 == 0);
    inf2  = (e2 == ExpMax) && (f2 == 0);
    nan1  = (e1 == ExpMax) && (f1 != 0);
    nan2  = (e2 == ExpMax) && (f2 != 0);
    if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
      r.s   = 1'b0;
      r.e   = 8'hFF;
      r.f   = 7'h40;
      r.inv = !(nan1 || nan2);
      return r;
    end
    if (inf1 || inf2) begin
      r.e = 8'hFF;
      return r;
    end
    if (zero1 || zero2) return r;
    p = (128 + int'(f1)) * (128 + int'(f2));
    k = 15;
    while (((p >> k) & 1) == 0) k--;
    sh   = k - FW;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh - 1);
    if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q++;
    if (q == 256) begin
      q = 128;
      k++;
    end
    be = int'(e1) + int'(e2) - Bias + (k - 2 * FW);
    if (be >= ExpMax) begin
      r.e   = 8'hFF;
      r.ovf = 1'b1;
    end else if (be <= 0) begin
      r.unf = 1'b1;
    end else begin
      r.e = be[EW-1:0];
      r.f = 7'(q - 128);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic s1, input logic [7:0] e1, input logic [6:0] f1,
                              input logic s2, input logic [7:0] e2, input logic [6:0] f2,
                              input logic rs, input logic [7:0] re, input logic [6:0] rf,
                              input logic ovf, input logic unf, input logic inv);
    vec_t v;
    v.s1 = s1; v.e1 = e1; v.f1 = f1;
    v.s2 = s2; v.e2 = e2; v.f2 = f2;
    v.exp = {rs, re, rf, ovf, unf, inv};
    return v;
  endfunction

  function automatic logic [EW-1:0] rand_exp();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'($urandom_range(1, 8));
      3: return 8'($urandom_range(8'hF0, 8'hFE));
      default: return 8'($urandom_range(8'h60, 8'hA0));
    endcase
  endfunction

  task automatic drive_ops(input logic s1, input logic [7:0] e1, input logic [6:0] f1,
                           input logic s2, input logic [7:0] e2, input logic [6:0] f2);
    op1_sign = s1; op1_exp = e1; op1_frac = f1;
    op2_sign = s2; op2_exp = e2; op2_frac = f2;
  endtask

  // Scoreboard monitor: records accepted operands and checks every result handed over.
  initial begin
    res_t prev, er, et;
    logic prev_hold;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) check("hold_stable", got, prev);
        check("twin_valid", out_valid_t, out_valid);
        if (in_valid && in_ready) begin
          exp_rne_q.push_back(model(op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac, 1));
          exp_trn_q.push_back(model(op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac, 0));
        end
        if (out_valid && out_ready) begin
          if (exp_rne_q.size() == 0) begin
            check("out_unexpected", out_valid, 1'b0);
          end else begin
            er = exp_rne_q.pop_front();
            et = exp_trn_q.pop_front();
            check("sb_rne", got, er);
            check("sb_trunc", got_t, et);
          end
        end
        prev_hold = out_valid && !out_ready;
        prev = got;
      end
    end
  end

  vec_t vecs[16];

  initial begin
    int accepted, stale, n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive_ops(0, 0, 0, 0, 0, 0);

    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res", got, 18'h0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    vecs[0]  = mk(0, 8'h7F, 7'h40, 0, 8'h7F, 7'h40, 0, 8'h80, 7'h10, 0, 0, 0);
    vecs[1]  = mk(0, 8'h7F, 7'h01, 0, 8'h7F, 7'h01, 0, 8'h7F, 7'h02, 0, 0, 0);
    vecs[2]  = mk(0, 8'hFE, 7'h00, 0, 8'h80, 7'h00, 0, 8'hFF, 7'h00, 1, 0, 0);
    vecs[3]  = mk(0, 8'h01, 7'h00, 0, 8'h01, 7'h00, 0, 8'h00, 7'h00, 0, 1, 0);
    vecs[4]  = mk(0, 8'hFF, 7'h00, 1, 8'h00, 7'h00, 0, 8'hFF, 7'h40, 0, 0, 1);
    vecs[5]  = mk(1, 8'hFF, 7'h00, 0, 8'h80, 7'h00, 1, 8'hFF, 7'h00, 0, 0, 0);
    vecs[6]  = mk(1, 8'hFF, 7'h01, 0, 8'h7F, 7'h00, 0, 8'hFF, 7'h40, 0, 0, 0);
    vecs[7]  = mk(1, 8'h00, 7'h55, 0, 8'h85, 7'h12, 1, 8'h00, 7'h00, 0, 0, 0);
    vecs[8]  = mk(0, 8'h7F, 7'h41, 0, 8'h7F, 7'h01, 0, 8'h7F, 7'h43, 0, 0, 0);
    vecs[9]  = mk(0, 8'h7F, 7'h40, 0, 8'h7F, 7'h01, 0, 8'h7F, 7'h42, 0, 0, 0);
    vecs[10] = mk(0, 8'h7F, 7'h40, 0, 8'h7F, 7'h03, 0, 8'h7F, 7'h44, 0, 0, 0);
    vecs[11] = mk(0, 8'h7F, 7'h35, 0, 8'h7F, 7'h35, 0, 8'h80, 7'h00, 0, 0, 0);
    vecs[12] = mk(0, 8'hFE, 7'h35, 0, 8'h7F, 7'h35, 0, 8'hFF, 7'h00, 1, 0, 0);
    vecs[13] = mk(0, 8'hFE, 7'h00, 1, 8'h7F, 7'h00, 1, 8'hFE, 7'h00, 0, 0, 0);
    vecs[14] = mk(0, 8'h01, 7'h00, 0, 8'h7E, 7'h00, 0, 8'h00, 7'h00, 0, 1, 0);
    vecs[15] = mk(1, 8'hFF, 7'h00, 1, 8'hFF, 7'h00, 0, 8'hFF, 7'h00, 0, 0, 0);

    // Directed vectors, one at a time, checking exact latency.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      drive_ops(vecs[i].s1, vecs[i].e1, vecs[i].f1, vecs[i].s2, vecs[i].e2, vecs[i].f2);
      in_valid = 1'b1;
      #1 check("vec_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 check($sformatf("vec%0d_early", i), out_valid, 1'b0);
      @(posedge clk);
      #1 check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d_res", i), got, vecs[i].exp);
    end

    // Random traffic with random back-pressure.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_ops(1'($urandom), rand_exp(), ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom),
                1'($urandom), rand_exp(), ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_rne_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", exp_rne_q.size(), 0);

    // Stall: consumer blocked while producer keeps offering operands.
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive_ops(0, 8'h7F, 7'(i * 5), 0, 8'h80, 7'h00);
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    check("stall_accepted", accepted, 3);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_first_res", got, {1'b0, 8'h80, 7'h00, 3'b000});
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("release_valid%0d", j), out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    check("release_empty", out_valid, 1'b0);

    // Reset with every stage full.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_ops(1, 8'h90, 7'h11, 0, 8'h70, 7'h22);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    exp_rne_q.delete();
    exp_trn_q.delete();
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_res", got, 18'h0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1'b1);
    stale = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("post_rst_stale", stale, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
